// File: rtl/writeback_stage_param_pkg.sv
// Shared encodings and pipeline-register control fields for the writeback stage.
// XLEN-sized data fields are added around wb_ctrl_t inside the top, because a package cannot take a parameter.
package riscv_wb_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_CSR = 2'b11;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic [1:0] ressrc;
    logic [4:0] rd;
    logic       ecc_corr;
    logic       ecc_uncorr;
  } wb_ctrl_t;

endpackage

// File: rtl/writeback_stage_param_if.sv
// MEM->WB handshake bundle: memory-stage results and pipeline control in, register-file write and diagnostics out.
// No valid/ready flow control; StallW holds the stage and FlushW invalidates it.
interface writeback_stage_param_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             StallW;
  logic             FlushW;
  logic             ValidM;
  logic             RegWriteM;
  logic [1:0]       ResultSrcM;
  logic [2:0]       LoadTypeM;
  logic [4:0]       RdM;
  logic [XLEN-1:0]  ALU_ResultM;
  logic [XLEN-1:0]  ReadDataM;
  logic [XLEN-1:0]  PCPlus4M;
  logic [XLEN-1:0]  CsrDataM;
  logic             EccCorrM;
  logic             EccUncorrM;
  logic             ErrClr;
  logic [XLEN-1:0]  ResultW;
  logic [4:0]       RdW;
  logic             RegWriteW;
  logic             ValidW;
  logic             EccErrSticky;
  logic [CNT_W-1:0] RetireCount;
  logic [CNT_W-1:0] CorrCount;

  modport master (
    output StallW, FlushW, ValidM, RegWriteM, ResultSrcM, LoadTypeM, RdM,
           ALU_ResultM, ReadDataM, PCPlus4M, CsrDataM, EccCorrM, EccUncorrM, ErrClr,
    input  ResultW, RdW, RegWriteW, ValidW, EccErrSticky, RetireCount, CorrCount
  );

  modport slave (
    input  StallW, FlushW, ValidM, RegWriteM, ResultSrcM, LoadTypeM, RdM,
           ALU_ResultM, ReadDataM, PCPlus4M, CsrDataM, EccCorrM, EccUncorrM, ErrClr,
    output ResultW, RdW, RegWriteW, ValidW, EccErrSticky, RetireCount, CorrCount
  );
endinterface

// File: rtl/writeback_stage_param_load_formatter.sv
// Combinational load formatter: extracts byte/half at the address offset and sign/zero-extends to XLEN.
// Zero latency, no backpressure.
module load_formatter
  import riscv_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] read_data,
  input  logic [1:0]      offset,
  input  logic [2:0]      load_type,
  output logic [XLEN-1:0] data_fmt
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword loads ignore offset[0]; misalignment is handled upstream.
  assign byte_sel = read_data[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? read_data[31:16] : read_data[15:0];

  always_comb begin
    data_fmt = XLEN'($signed(read_data[31:0]));
    case (load_type)
      LD_B:    data_fmt = XLEN'($signed(byte_sel));
      LD_H:    data_fmt = XLEN'($signed(half_sel));
      LD_BU:   data_fmt = XLEN'(byte_sel);
      LD_HU:   data_fmt = XLEN'(half_sel);
      default: data_fmt = XLEN'($signed(read_data[31:0]));
    endcase
  end

endmodule

// File: rtl/writeback_stage_param.sv
// MEM/WB pipeline register with result select, register-file write gating, retire/ECC counters and error sticky.
// One cycle M->W latency; StallW holds the slot, FlushW invalidates it (flush wins).
module writeback_stage_param
  import riscv_wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  writeback_stage_param_if.slave bus
);

  typedef struct packed {
    wb_ctrl_t        ctrl;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] mem_fmt;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] csr;
  } wb_reg_t;

  logic [XLEN-1:0] mem_fmt;
  wb_reg_t         wb_d;
  wb_reg_t         wb_q;
  logic            load_bad;
  logic            retire;
  logic            sticky_set;
  logic            err_sticky;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] corr_cnt;

  load_formatter #(.XLEN(XLEN)) u_load_formatter (
    .read_data (bus.ReadDataM),
    .offset    (bus.ALU_ResultM[1:0]),
    .load_type (bus.LoadTypeM),
    .data_fmt  (mem_fmt)
  );

  always_comb begin
    wb_d                 = '0;
    wb_d.ctrl.valid      = bus.ValidM;
    wb_d.ctrl.regwrite   = bus.RegWriteM;
    wb_d.ctrl.ressrc     = bus.ResultSrcM;
    wb_d.ctrl.rd         = bus.RdM;
    wb_d.ctrl.ecc_corr   = bus.EccCorrM;
    wb_d.ctrl.ecc_uncorr = bus.EccUncorrM;
    wb_d.alu             = bus.ALU_ResultM;
    wb_d.mem_fmt         = mem_fmt;
    wb_d.pc4             = bus.PCPlus4M;
    wb_d.csr             = bus.CsrDataM;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q <= '0;
    end else if (bus.FlushW) begin
      wb_q.ctrl.valid      <= 1'b0;
      wb_q.ctrl.ecc_corr   <= 1'b0;
      wb_q.ctrl.ecc_uncorr <= 1'b0;
    end else if (!bus.StallW) begin
      wb_q <= wb_d;
    end
  end

  always_comb begin
    bus.ResultW = wb_q.alu;
    case (wb_q.ctrl.ressrc)
      RES_MEM: bus.ResultW = wb_q.mem_fmt;
      RES_PC4: bus.ResultW = wb_q.pc4;
      RES_CSR: bus.ResultW = wb_q.csr;
      default: bus.ResultW = wb_q.alu;
    endcase
  end

  assign load_bad      = wb_q.ctrl.ecc_uncorr & (wb_q.ctrl.ressrc == RES_MEM);
  assign bus.RegWriteW = wb_q.ctrl.valid & wb_q.ctrl.regwrite & (wb_q.ctrl.rd != 5'd0) & ~load_bad;
  assign bus.RdW       = wb_q.ctrl.rd;
  assign bus.ValidW    = wb_q.ctrl.valid;

  // A held slot retires only on the edge it is released, so stalls never double-count.
  assign retire     = ~bus.StallW & wb_q.ctrl.valid & ~wb_q.ctrl.ecc_uncorr;
  assign sticky_set = bus.ValidM & bus.EccUncorrM & (bus.ResultSrcM == RES_MEM)
                    & ~bus.StallW & ~bus.FlushW;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt <= '0;
      corr_cnt   <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (retire && (retire_cnt != '1)) retire_cnt <= retire_cnt + 1'b1;
      if (retire && wb_q.ctrl.ecc_corr && (corr_cnt != '1)) corr_cnt <= corr_cnt + 1'b1;
      if (sticky_set)      err_sticky <= 1'b1;
      else if (bus.ErrClr) err_sticky <= 1'b0;
    end
  end

  assign bus.RetireCount  = retire_cnt;
  assign bus.CorrCount    = corr_cnt;
  assign bus.EccErrSticky = err_sticky;

endmodule

// File: tb/tb_writeback_stage_param.sv
// Bench for writeback_stage_param: directed scenarios plus random traffic against a behavioural model.
module tb_writeback_stage_param;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;

  typedef struct {
    bit        valid, regwrite, corr, uncorr, stall, flush, clr;
    bit [1:0]  src;
    bit [2:0]  lt;
    bit [4:0]  rd;
    bit [31:0] alu, rdata, pc4, csr;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  bit        m_valid, m_regwrite, m_corr, m_uncorr, m_sticky;
  bit [1:0]  m_src;
  bit [4:0]  m_rd;
  bit [31:0] m_res;
  int        m_retire, m_corrc;

  bit [2:0]  ld_lt  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b101};
  bit [1:0]  ld_off [7] = '{2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1};
  bit [31:0] ld_exp [7] = '{32'hFFFF_FF80, 32'h0000_0081, 32'hFFFF_8081, 32'h0000_7F80,
                            32'h8081_7F80, 32'hFFFF_8081, 32'h0000_7F80};

  writeback_stage_param_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  writeback_stage_param #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic bit [31:0] fmt_load(bit [31:0] w, bit [1:0] off, bit [2:0] lt);
    bit [31:0] b, h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
    case (lt)
      3'b000:  return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic bit exp_regwrite();
    return m_valid && m_regwrite && (m_rd != 0) && !(m_uncorr && m_src == 2'b01);
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_regwrite = 0; m_corr = 0; m_uncorr = 0; m_sticky = 0;
    m_src = 0; m_rd = 0; m_res = 0; m_retire = 0; m_corrc = 0;
  endtask

  task automatic apply(input stim_t s);
    bus.ValidM = s.valid;   bus.RegWriteM = s.regwrite; bus.ResultSrcM = s.src;
    bus.LoadTypeM = s.lt;   bus.RdM = s.rd;             bus.ALU_ResultM = s.alu;
    bus.ReadDataM = s.rdata; bus.PCPlus4M = s.pc4;      bus.CsrDataM = s.csr;
    bus.EccCorrM = s.corr;  bus.EccUncorrM = s.uncorr;  bus.StallW = s.stall;
    bus.FlushW = s.flush;   bus.ErrClr = s.clr;
  endtask

  // Drive on the falling edge, advance the model at the rising edge, return at the next falling edge.
  task automatic drive_cycle(input stim_t s);
    apply(s);
    @(posedge clk);
    if (!s.stall && m_valid && !m_uncorr) begin
      if (m_retire < CNT_MAX) m_retire++;
      if (m_corr && m_corrc < CNT_MAX) m_corrc++;
    end
    if (s.valid && s.uncorr && s.src == 2'b01 && !s.stall && !s.flush) m_sticky = 1;
    else if (s.clr) m_sticky = 0;
    if (s.flush) begin
      m_valid = 0; m_corr = 0; m_uncorr = 0;
    end else if (!s.stall) begin
      m_valid = s.valid; m_regwrite = s.regwrite; m_src = s.src; m_rd = s.rd;
      m_corr = s.corr; m_uncorr = s.uncorr;
      case (s.src)
        2'b00:   m_res = s.alu;
        2'b01:   m_res = fmt_load(s.rdata, s.alu[1:0], s.lt);
        2'b10:   m_res = s.pc4;
        default: m_res = s.csr;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t s;
    rst = 1'b0;
    apply(idle());
    repeat (2) @(negedge clk);
    n_checks++; if (bus.ValidW !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0h exp=0", bus.ValidW); end
    n_checks++; if (bus.RegWriteW !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite got=%0h exp=0", bus.RegWriteW); end
    n_checks++; if (bus.ResultW !== 32'h0 || bus.RdW !== 5'd0) begin n_fail++; $display("FAIL reset_data result=%0h rd=%0h exp=0", bus.ResultW, bus.RdW); end
    n_checks++; if (bus.RetireCount !== 8'd0 || bus.CorrCount !== 8'd0 || bus.EccErrSticky !== 1'b0) begin
      n_fail++; $display("FAIL reset_counters ret=%0d corr=%0d sticky=%0h exp=0", bus.RetireCount, bus.CorrCount, bus.EccErrSticky); end
    rst = 1'b1;
    model_reset();
    s = idle(); s.valid = 1; s.regwrite = 1; s.rd = 5'd9; s.alu = 32'h1234;
    drive_cycle(s);
    drive_cycle(s);
    n_checks++; if (bus.ValidW !== 1'b1 || bus.RegWriteW !== 1'b1 || bus.RetireCount !== 8'd1) begin
      n_fail++; $display("FAIL pre_reset valid=%0h we=%0h ret=%0d exp=1/1/1", bus.ValidW, bus.RegWriteW, bus.RetireCount); end
    #1 rst = 1'b0;
    #1;
    n_checks++; if (bus.ValidW !== 1'b0 || bus.RegWriteW !== 1'b0 || bus.RetireCount !== 8'd0) begin
      n_fail++; $display("FAIL async_reset valid=%0h we=%0h ret=%0d exp=0/0/0", bus.ValidW, bus.RegWriteW, bus.RetireCount); end
    apply(idle());
    rst = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_loads();
    stim_t s;
    for (int i = 0; i < 7; i++) begin
      s = idle(); s.valid = 1; s.regwrite = 1; s.src = 2'b01; s.rd = 5'(i + 1);
      s.lt = ld_lt[i]; s.alu = {30'd0, ld_off[i]}; s.rdata = 32'h8081_7F80;
      drive_cycle(s);
      n_checks++; if (bus.ResultW !== ld_exp[i] || bus.RegWriteW !== 1'b1) begin
        n_fail++; $display("FAIL load_%0d got=%08h we=%0h exp=%08h we=1", i, bus.ResultW, bus.RegWriteW, ld_exp[i]); end
    end
  endtask

  task automatic test_mux_x0();
    stim_t s;
    int    ret0;
    s = idle(); s.valid = 1; s.regwrite = 1; s.src = 2'b10; s.rd = 5'd5; s.pc4 = 32'h104; s.alu = 32'hDEAD;
    drive_cycle(s);
    n_checks++; if (bus.ResultW !== 32'h104 || bus.RegWriteW !== 1'b1 || bus.RdW !== 5'd5) begin
      n_fail++; $display("FAIL mux_pc4 got=%0h we=%0h rd=%0d exp=104/1/5", bus.ResultW, bus.RegWriteW, bus.RdW); end
    s.rd = 5'd0;
    drive_cycle(s);
    ret0 = m_retire;
    n_checks++; if (bus.RegWriteW !== 1'b0 || bus.ValidW !== 1'b1) begin
      n_fail++; $display("FAIL x0_write we=%0h valid=%0h exp=0/1", bus.RegWriteW, bus.ValidW); end
    s = idle(); s.valid = 1; s.regwrite = 1; s.src = 2'b11; s.rd = 5'd12; s.csr = 32'hC5C5_0001;
    drive_cycle(s);
    n_checks++; if (bus.RetireCount !== 8'(ret0 + 1)) begin
      n_fail++; $display("FAIL x0_retire got=%0d exp=%0d", bus.RetireCount, ret0 + 1); end
    n_checks++; if (bus.ResultW !== 32'hC5C5_0001) begin
      n_fail++; $display("FAIL mux_csr got=%0h exp=c5c50001", bus.ResultW); end
  endtask

  task automatic test_stall_flush();
    stim_t s;
    int    ret0;
    s = idle(); s.valid = 1; s.regwrite = 1; s.rd = 5'd3; s.alu = 32'hA5A5_0003;
    drive_cycle(s);
    ret0 = m_retire;
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.valid = 1; s.regwrite = 1; s.rd = 5'(20 + i); s.alu = $urandom; s.stall = 1;
      drive_cycle(s);
      n_checks++; if (bus.ResultW !== 32'hA5A5_0003 || bus.RdW !== 5'd3 || bus.ValidW !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold_%0d res=%0h rd=%0d exp=a5a50003/3", i, bus.ResultW, bus.RdW); end
      n_checks++; if (bus.RetireCount !== 8'(ret0)) begin
        n_fail++; $display("FAIL stall_retire_%0d got=%0d exp=%0d", i, bus.RetireCount, ret0); end
    end
    drive_cycle(idle());
    n_checks++; if (bus.RetireCount !== 8'(ret0 + 1)) begin
      n_fail++; $display("FAIL stall_release got=%0d exp=%0d", bus.RetireCount, ret0 + 1); end
    s = idle(); s.valid = 1; s.regwrite = 1; s.rd = 5'd4;
    drive_cycle(s);
    s.flush = 1; s.stall = 1;
    drive_cycle(s);
    n_checks++; if (bus.ValidW !== 1'b0 || bus.RegWriteW !== 1'b0) begin
      n_fail++; $display("FAIL flush_stall valid=%0h we=%0h exp=0/0", bus.ValidW, bus.RegWriteW); end
  endtask

  task automatic test_ecc();
    stim_t s;
    int    ret0, corr0;
    drive_cycle(idle());
    ret0 = m_retire;
    s = idle(); s.valid = 1; s.regwrite = 1; s.src = 2'b01; s.lt = 3'b010; s.rd = 5'd7;
    s.rdata = 32'h1111_2222; s.uncorr = 1;
    drive_cycle(s);
    n_checks++; if (bus.RegWriteW !== 1'b0 || bus.EccErrSticky !== 1'b1) begin
      n_fail++; $display("FAIL ecc_uncorr we=%0h sticky=%0h exp=0/1", bus.RegWriteW, bus.EccErrSticky); end
    drive_cycle(idle());
    n_checks++; if (bus.RetireCount !== 8'(ret0)) begin
      n_fail++; $display("FAIL ecc_no_retire got=%0d exp=%0d", bus.RetireCount, ret0); end
    corr0 = m_corrc;
    s.uncorr = 0; s.corr = 1; s.clr = 1;
    drive_cycle(s);
    n_checks++; if (bus.RegWriteW !== 1'b1 || bus.ResultW !== 32'h1111_2222 || bus.EccErrSticky !== 1'b0) begin
      n_fail++; $display("FAIL ecc_corr_write we=%0h res=%0h sticky=%0h exp=1/11112222/0", bus.RegWriteW, bus.ResultW, bus.EccErrSticky); end
    s.corr = 0; s.uncorr = 1; s.clr = 0;
    drive_cycle(s);
    n_checks++; if (bus.CorrCount !== 8'(corr0 + 1)) begin
      n_fail++; $display("FAIL ecc_corr_count got=%0d exp=%0d", bus.CorrCount, corr0 + 1); end
    s.clr = 1;
    drive_cycle(s);
    n_checks++; if (bus.EccErrSticky !== 1'b1) begin
      n_fail++; $display("FAIL ecc_set_wins got=%0h exp=1", bus.EccErrSticky); end
    s = idle(); s.clr = 1;
    drive_cycle(s);
    n_checks++; if (bus.EccErrSticky !== 1'b0) begin
      n_fail++; $display("FAIL ecc_clear got=%0h exp=0", bus.EccErrSticky); end
  endtask

  task automatic test_random();
    stim_t s;
    rst = 1'b0; #1 rst = 1'b1;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      s.valid = ($urandom_range(0, 3) != 0);  s.regwrite = ($urandom_range(0, 4) != 0);
      s.src = 2'($urandom_range(0, 3));        s.lt = 3'($urandom_range(0, 7));
      s.rd = 5'($urandom_range(0, 31));        s.alu = $urandom; s.rdata = $urandom;
      s.pc4 = $urandom; s.csr = $urandom;
      s.corr   = (s.src == 2'b01) && ($urandom_range(0, 4) == 0);
      s.uncorr = (s.src == 2'b01) && ($urandom_range(0, 7) == 0);
      s.stall = ($urandom_range(0, 4) == 0);   s.flush = ($urandom_range(0, 9) == 0);
      s.clr   = ($urandom_range(0, 9) == 0);
      drive_cycle(s);
      n_checks++; if (bus.ValidW !== m_valid || bus.RegWriteW !== exp_regwrite()) begin
        n_fail++; $display("FAIL rnd_ctrl_%0d valid=%0h we=%0h exp=%0h/%0h", i, bus.ValidW, bus.RegWriteW, m_valid, exp_regwrite()); end
      if (m_valid) begin
        n_checks++; if (bus.ResultW !== m_res || bus.RdW !== m_rd) begin
          n_fail++; $display("FAIL rnd_data_%0d res=%0h rd=%0d exp=%0h/%0d", i, bus.ResultW, bus.RdW, m_res, m_rd); end
      end
      n_checks++; if (bus.RetireCount !== 8'(m_retire) || bus.CorrCount !== 8'(m_corrc) || bus.EccErrSticky !== m_sticky) begin
        n_fail++; $display("FAIL rnd_diag_%0d ret=%0d corr=%0d sticky=%0h exp=%0d/%0d/%0h", i,
                           bus.RetireCount, bus.CorrCount, bus.EccErrSticky, m_retire, m_corrc, m_sticky); end
    end
  endtask

  task automatic test_saturation();
    stim_t s;
    rst = 1'b0; #1 rst = 1'b1;
    model_reset();
    s = idle(); s.valid = 1; s.regwrite = 1; s.rd = 5'd1;
    for (int i = 0; i < CNT_MAX; i++) drive_cycle(s);
    drive_cycle(idle());
    n_checks++; if (bus.RetireCount !== 8'hFF) begin
      n_fail++; $display("FAIL sat_reach got=%0d exp=255", bus.RetireCount); end
    drive_cycle(s);
    drive_cycle(idle());
    n_checks++; if (bus.RetireCount !== 8'hFF || bus.CorrCount !== 8'd0) begin
      n_fail++; $display("FAIL sat_hold ret=%0d corr=%0d exp=255/0", bus.RetireCount, bus.CorrCount); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_mux_x0();
    test_stall_flush();
    test_ecc();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
